ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX/MEM pipeline boundary directly downstream of the ALU. Captures ALU result, zero
//  flag and EX-stage control/payload into a 2-entry skid buffer with valid/ready
//  handshakes on both sides. Resolves the branch decision for the MEM stage.
//  Isolates the EX and MEM stages so that a MEM stall never corrupts or drops an in-flight instruction.
// PARAMETERS
//  DATA_W  32  width of ALU result and store data
//  REG_W   5   register-file index width
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous, active-low reset
//  flush          in   1       synchronous; kill all buffered entries
//  in_valid       in   1       EX entry valid
//  in_ready       out  1       buffer can accept this cycle
//  in_result      in   DATA_W  ALU result
//  in_zero        in   1       ALU zero flag
//  in_store_data  in   DATA_W  rt value for SW
//  in_dest        in   REG_W   write-back register index
//  in_ctrl        in   5       {reg_write, mem_read, mem_write, mem_to_reg, branch}
//  out_valid      out  1       MEM entry valid
//  out_ready      in   1       MEM consumes this cycle
//  out_result / out_zero / out_store_data / out_dest / out_ctrl  out  (same widths)  head entry
//  branch_taken   out  1       out_valid & out_ctrl[0] & out_zero (combinational from regs)
// BEHAVIOUR
//  - Reset (rst_n=0, async): both entries invalid, all payload regs 0, in_ready=1, out_valid=0.
//  - Storage: head reg (drives out_*) + skid reg. in_ready = ~skid_valid (registered, no comb path from out_ready).
//  - Accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - Latency: 1 cycle in_valid->out_valid when empty; full throughput with out_ready=1.
//  - Per cycle (no flush):
//    head empty or pop: head <= skid if skid_valid, else incoming if accept, else invalid;
//      if skid moved to head and accept, incoming -> skid, else skid invalid.
//    head held (out_valid & ~out_ready): accept goes to skid; skid_valid <= 1.
//  - Head payload stable while out_valid & ~out_ready. Order strictly FIFO; no loss/duplication.
//  - Flush: next cycle head and skid invalid, in_ready=1; same-cycle accept dropped; pop still
//    counts as consumed. Flush beats accept. Payload regs may keep stale data (valid=0).
//  - Full: skid_valid=1 -> in_ready=0; upstream must hold in_* stable.
//  - Simultaneous pop + accept with skid full: skid->head, incoming->skid (in_ready was 0, so
//    cannot occur; accept impossible while full).
//  - Reset mid-stream: immediate clear, no output handshake completes.
//  - branch_taken forced 0 when out_valid=0.
//  - in_zero is passed through unmodified; no recomputation from result.
// CONFIGURATION
//  EXMEM_FWD_EN defined: extra outputs fwd_valid(1), fwd_dest(REG_W), fwd_data(DATA_W)
//    from head: fwd_valid = out_valid & out_ctrl[4] & ~out_ctrl[3] & (out_dest != 0);
//    fwd_dest=out_dest, fwd_data=out_result. Feeds EX forwarding mux.
//  EXMEM_FWD_EN undefined: those ports and logic absent; behaviour otherwise identical.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1, out_result=0 immediately (async).
//  2 Stream: out_ready=1, 4 back-to-back entries result=1..4 -> out_valid each cycle from
//    cycle+1, results 1,2,3,4 in order, in_ready stays 1.
//  3 Backpressure: out_ready=0, send A=0xA,B=0xB -> head=0xA, in_ready=0; C=0xC held;
//    out_ready=1 -> outputs 0xA,0xB,0xC consecutive, no dup/loss.
//  4 Branch: ctrl branch=1, result=0, zero=1 -> branch_taken=1 while entry at head; zero=0 -> 0.
//  5 Flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped entry
//    never appears.
//  6 EXMEM_FWD_EN: reg_write=1, mem_read=0, dest=8, result=0x1234 -> fwd_valid=1, fwd_dest=8,
//    fwd_data=0x1234; dest=0 -> fwd_valid=0; mem_read=1 -> fwd_valid=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: 2-entry skid buffer (head + skid) with valid/ready on both sides.
// Optional EXMEM_FWD_EN adds head-entry forwarding outputs (fwd_valid/fwd_dest/fwd_data).
module ex_mem_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_dest,
    input  logic [4:0]        in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_dest,
    output logic [4:0]        out_ctrl,
    output logic              branch_taken
`ifdef EXMEM_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_dest,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    // Packed payload: {result, zero, store_data, dest, ctrl}
    localparam int unsigned PW = 2 * DATA_W + REG_W + 6;

    logic [PW-1:0] in_pay;
    logic [PW-1:0] head_q, skid_q;
    logic          head_valid_q, skid_valid_q;
    logic          accept, pop;

    assign in_pay   = {in_result, in_zero, in_store_data, in_dest, in_ctrl};
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign pop      = head_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            // Pending accept is dropped; a same-cycle pop was already consumed downstream.
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!head_valid_q || pop) begin
            if (skid_valid_q) begin
                head_q       <= skid_q;
                head_valid_q <= 1'b1;
                if (accept) begin
                    skid_q       <= in_pay;
                    skid_valid_q <= 1'b1;
                end else begin
                    skid_valid_q <= 1'b0;
                end
            end else if (accept) begin
                head_q       <= in_pay;
                head_valid_q <= 1'b1;
            end else begin
                head_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= in_pay;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid = head_valid_q;
    assign {out_result, out_zero, out_store_data, out_dest, out_ctrl} = head_q;
    assign branch_taken = head_valid_q & out_ctrl[0] & out_zero;

`ifdef EXMEM_FWD_EN
    // Loads are excluded: their data is not known until after MEM.
    assign fwd_valid = head_valid_q & out_ctrl[4] & ~out_ctrl[3] & (out_dest != '0);
    assign fwd_dest  = out_dest;
    assign fwd_data  = out_result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; forwarding checks only when EXMEM_FWD_EN is set.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_zero;
    logic [31:0] in_store_data;
    logic [4:0]  in_dest;
    logic [4:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [31:0] out_store_data;
    logic [4:0]  out_dest;
    logic [4:0]  out_ctrl;
    logic        branch_taken;
`ifdef EXMEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_zero       (in_zero),
        .in_store_data (in_store_data),
        .in_dest       (in_dest),
        .in_ctrl       (in_ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_store_data(out_store_data),
        .out_dest      (out_dest),
        .out_ctrl      (out_ctrl),
        .branch_taken  (branch_taken)
`ifdef EXMEM_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_dest      (fwd_dest),
        .fwd_data      (fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic z,
                         input logic [4:0] d, input logic [4:0] c);
        in_valid      = v;
        in_result     = r;
        in_zero       = z;
        in_store_data = r ^ 32'hFFFF_0000;
        in_dest       = d;
        in_ctrl       = c;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        #3;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        check("rst_branch", {63'd0, branch_taken}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Back-to-back stream, full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0, 5'(i + 2), 5'b10000);
            step();
            check("stream_valid", {63'd0, out_valid}, 64'd1);
            check("stream_result", {32'd0, out_result}, 64'(i));
            check("stream_store", {32'd0, out_store_data}, 64'(i ^ 32'hFFFF_0000));
            check("stream_dest", {59'd0, out_dest}, 64'(i + 2));
            check("stream_in_ready", {63'd0, in_ready}, 64'd1);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        step();
        check("stream_drain", {63'd0, out_valid}, 64'd0);

        // Backpressure: A in head, B in skid, C held upstream
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b0, 5'd1, 5'd0);
        step();
        check("bp_head_a", {32'd0, out_result}, 64'hA);
        check("bp_ready_1", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 32'hB, 1'b0, 5'd2, 5'd0);
        step();
        check("bp_hold_a", {32'd0, out_result}, 64'hA);
        check("bp_full", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'hC, 1'b0, 5'd3, 5'd0);
        step();
        check("bp_stable_a", {32'd0, out_result}, 64'hA);
        check("bp_stable_dest", {59'd0, out_dest}, 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_out_b", {32'd0, out_result}, 64'hB);
        check("bp_ready_again", {63'd0, in_ready}, 64'd1);
        step();
        check("bp_out_c", {32'd0, out_result}, 64'hC);
        check("bp_valid_c", {63'd0, out_valid}, 64'd1);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        step();
        check("bp_no_dup", {63'd0, out_valid}, 64'd0);

        // Branch resolution
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 1'b1, 5'd0, 5'b00001);
        step();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        check("br_taken", {63'd0, branch_taken}, 64'd1);
        check("br_zero_pass", {63'd0, out_zero}, 64'd1);
        step();
        check("br_taken_held", {63'd0, branch_taken}, 64'd1);
        out_ready = 1'b1;
        step();
        check("br_gone", {63'd0, branch_taken}, 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 1'b0, 5'd0, 5'b00001);
        step();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        check("br_nz_valid", {63'd0, out_valid}, 64'd1);
        check("br_not_taken", {63'd0, branch_taken}, 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Flush with skid full and a pending entry
        drive(1'b1, 32'h51, 1'b0, 5'd1, 5'd0);
        step();
        drive(1'b1, 32'h52, 1'b0, 5'd2, 5'd0);
        step();
        check("fl_full", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'h53, 1'b0, 5'd3, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", {63'd0, out_valid}, 64'd0);
        check("fl_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        out_ready = 1'b1;
        step();
        check("fl_no_ghost", {63'd0, out_valid}, 64'd0);
        // Flush beats an accept on an empty buffer
        drive(1'b1, 32'h61, 1'b0, 5'd1, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        check("fl_accept_dropped", {63'd0, out_valid}, 64'd0);

`ifdef EXMEM_FWD_EN
        out_ready = 1'b0;
        drive(1'b1, 32'h1234, 1'b0, 5'd8, 5'b10000);
        step();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        check("fwd_valid", {63'd0, fwd_valid}, 64'd1);
        check("fwd_dest", {59'd0, fwd_dest}, 64'd8);
        check("fwd_data", {32'd0, fwd_data}, 64'h1234);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h1234, 1'b0, 5'd0, 5'b10000);
        step();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        check("fwd_dest0", {63'd0, fwd_valid}, 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h1234, 1'b0, 5'd8, 5'b11000);
        step();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        check("fwd_load", {63'd0, fwd_valid}, 64'd0);
        out_ready = 1'b1;
        step();
`endif

        // Asynchronous reset mid-stream with an entry at the head
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 1'b0, 5'd4, 5'b00001);
        step();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        check("mid_loaded", {32'd0, out_result}, 64'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_result", {32'd0, out_result}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", {63'd0, out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
